// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, NOP encoding
// and the fetch-stage state encoding.
package cpu_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [31:0] NOP = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_next_pc.sv
// Next-PC arithmetic: sequential PC+4 and the
// aligned redirect target (branch over jump).
module next_pc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] link_pc4,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  output logic [ADDR_W-1:0] seq_pc,
  output logic [ADDR_W-1:0] target,
  output logic              redirect
);

  localparam logic [ADDR_W-1:0] ALIGN =
    {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] HI_MASK =
    {{(ADDR_W-28){1'b1}}, 28'h0};

  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] jmp_tgt;

  assign seq_pc  = pc + ADDR_W'(4);
  assign br_tgt  = branch_target & ALIGN;
  assign jmp_tgt = (link_pc4 & HI_MASK)
                 | ADDR_W'({jump_index, 2'b00});

  assign redirect = branch_taken | jump;

  // branch has priority over jump
  always_comb begin
    target = jmp_tgt;
    if (branch_taken) target = br_tgt;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding
// imem port, redirect/drain, IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_valid,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc4,
  output logic              if_id_valid,
  output logic [5:0]        opcode
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] drain_addr;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] target;
  logic              redir_req;
  logic              redirect;

  next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc            (pc),
    .link_pc4      (if_id_pc4),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .seq_pc        (seq_pc),
    .target        (target),
    .redirect      (redir_req)
  );

  // redirects need a real instruction in IF/ID
  assign redirect = if_id_valid & redir_req;

  assign imem_req =
    (state == ST_DRAIN) ||
    ((state == ST_FETCH) && !stall);

  assign imem_addr =
    (state == ST_DRAIN) ? drain_addr : pc;

  assign opcode = if_id_instr[DATA_W-1 -: 6];

  // fetch FSM, PC and IF/ID register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      drain_addr  <= '0;
      if_id_instr <= DATA_W'(NOP);
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (redirect) begin
            pc          <= target;
            if_id_instr <= DATA_W'(NOP);
            if_id_valid <= 1'b0;
            if (imem_req && !imem_valid) begin
              state      <= ST_DRAIN;
              drain_addr <= pc;
            end
          end else if (stall) begin
            pc <= pc;
          end else if (imem_valid) begin
            pc          <= seq_pc;
            if_id_instr <= imem_rdata;
            if_id_pc4   <= seq_pc;
            if_id_valid <= 1'b1;
          end else begin
            if_id_instr <= DATA_W'(NOP);
            if_id_valid <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (redirect) begin
            pc          <= target;
            if_id_instr <= DATA_W'(NOP);
            if_id_valid <= 1'b0;
          end
          if (imem_valid) state <= ST_FETCH;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
